// File: rtl/fight_pkg.sv
// Shared fighting-game definitions: reaction state encoding, default stun and
// knockback constants, and the screen coordinate width used by the collision stage.
package fight_pkg;

   localparam int COORD_W = 10;
   localparam int STUN_W  = 6;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_HITSTUN   = 2'd1;
   localparam logic [1:0] ST_BLOCKSTUN = 2'd2;
   localparam logic [1:0] ST_KO        = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE      = ST_IDLE,
      S_HITSTUN   = ST_HITSTUN,
      S_BLOCKSTUN = ST_BLOCKSTUN,
      S_KO        = ST_KO
   } hr_state_e;

   localparam int DEF_HITSTUN_FRAMES   = 20;
   localparam int DEF_BLOCKSTUN_FRAMES = 10;
   localparam int DEF_KB_HIT_PX        = 8;
   localparam int DEF_KB_BLOCK_PX      = 3;

   // Knockback pushes the player away from the side it faces.
   function automatic logic signed [COORD_W-1:0] kb_signed(input int px,
                                                           input logic facing_right);
      logic signed [COORD_W-1:0] mag;
      mag = COORD_W'(px);
      return facing_right ? -mag : mag;
   endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Frame-tick-qualified rising-edge detector on the hit/block contact lines.
// A hit outranks a simultaneous block; a held overlap yields one edge only.
module frame_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_tick_i,
   input  logic clear_i,
   input  logic hit_i,
   input  logic blocked_i,
   output logic new_hit_o,
   output logic new_block_o
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      // NOTE: default assigned first so every path drives prev_d and no latch is inferred.
      prev_d = prev_q;
      if (clear_i) begin
         prev_d = 1'b0;
      end else if (frame_tick_i) begin
         prev_d = hit_i | blocked_i;
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign new_hit_o   = frame_tick_i & hit_i & ~prev_q;
   assign new_block_o = frame_tick_i & blocked_i & ~hit_i & ~prev_q;

endmodule

// File: rtl/hit_reaction_ctrl.sv
// Per-player hit reaction: stun FSM, health, KO latch and knockback request,
// driven by frame-sampled contact edges from the collision check.
module hit_reaction_ctrl
   import fight_pkg::*;
#(
   parameter int HEALTH_W         = 8,
   parameter int MAX_HEALTH       = 100,
   parameter int HIT_DAMAGE       = 20,
   parameter int HITSTUN_FRAMES   = DEF_HITSTUN_FRAMES,
   parameter int BLOCKSTUN_FRAMES = DEF_BLOCKSTUN_FRAMES,
   parameter int KB_HIT_PX        = DEF_KB_HIT_PX,
   parameter int KB_BLOCK_PX      = DEF_KB_BLOCK_PX
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      frame_tick,
   input  logic                      round_reset,
   input  logic                      got_hit,
   input  logic                      got_blocked,
   input  logic                      facing_right,
   output logic                      in_hitstun,
   output logic                      in_blockstun,
   output logic                      ko,
   output logic [HEALTH_W-1:0]       health,
   output logic                      hit_event,
   output logic                      block_event,
   output logic                      kb_valid,
   output logic signed [COORD_W-1:0] kb_dx
);

   localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(MAX_HEALTH);
   localparam logic [HEALTH_W-1:0] DAMAGE      = HEALTH_W'(HIT_DAMAGE);
   localparam logic [STUN_W-1:0]   HSTUN_LEN   = STUN_W'(HITSTUN_FRAMES);
   localparam logic [STUN_W-1:0]   BSTUN_LEN   = STUN_W'(BLOCKSTUN_FRAMES);

   hr_state_e                 state_q, state_d;
   logic [STUN_W-1:0]         stun_cnt_q, stun_cnt_d;
   logic [HEALTH_W-1:0]       health_q, health_d;
   logic                      hit_ev_q, hit_ev_d;
   logic                      blk_ev_q, blk_ev_d;
   logic                      kb_valid_q, kb_valid_d;
   logic signed [COORD_W-1:0] kb_dx_q, kb_dx_d;

   logic new_hit;
   logic new_block;
   logic accept_hit;
   logic accept_block;
   logic in_stun;

   frame_edge_detect u_edge (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick_i (frame_tick),
      .clear_i      (round_reset),
      .hit_i        (got_hit),
      .blocked_i    (got_blocked),
      .new_hit_o    (new_hit),
      .new_block_o  (new_block)
   );

   // Guard crush: a fresh hit also breaks an ongoing block stun.
   assign accept_hit   = new_hit & ((state_q == S_IDLE) | (state_q == S_BLOCKSTUN));
   assign accept_block = new_block & (state_q == S_IDLE);
   assign in_stun      = (state_q == S_HITSTUN) | (state_q == S_BLOCKSTUN);

   always_comb begin
      state_d    = state_q;
      stun_cnt_d = stun_cnt_q;
      health_d   = health_q;
      hit_ev_d   = 1'b0;
      blk_ev_d   = 1'b0;
      kb_valid_d = 1'b0;
      kb_dx_d    = '0;

      if (round_reset) begin
         state_d    = S_IDLE;
         stun_cnt_d = '0;
         health_d   = HEALTH_FULL;
      end else if (accept_hit) begin
         health_d   = (health_q > DAMAGE) ? health_q - DAMAGE : '0;
         hit_ev_d   = 1'b1;
         kb_valid_d = 1'b1;
         kb_dx_d    = kb_signed(KB_HIT_PX, facing_right);
         if (health_d == '0) begin
            state_d    = S_KO;
            stun_cnt_d = '0;
         end else begin
            state_d    = S_HITSTUN;
            stun_cnt_d = HSTUN_LEN;
         end
      end else if (accept_block) begin
         state_d    = S_BLOCKSTUN;
         stun_cnt_d = BSTUN_LEN;
         blk_ev_d   = 1'b1;
         kb_valid_d = 1'b1;
         kb_dx_d    = kb_signed(KB_BLOCK_PX, facing_right);
      end else if (frame_tick && in_stun) begin
         // The tick that takes the count from 1 to 0 ends the stun.
         if (stun_cnt_q <= STUN_W'(1)) begin
            state_d    = S_IDLE;
            stun_cnt_d = '0;
         end else begin
            stun_cnt_d = stun_cnt_q - STUN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         stun_cnt_q <= '0;
         health_q   <= HEALTH_FULL;
         hit_ev_q   <= 1'b0;
         blk_ev_q   <= 1'b0;
         kb_valid_q <= 1'b0;
         kb_dx_q    <= '0;
      end else begin
         state_q    <= state_d;
         stun_cnt_q <= stun_cnt_d;
         health_q   <= health_d;
         hit_ev_q   <= hit_ev_d;
         blk_ev_q   <= blk_ev_d;
         kb_valid_q <= kb_valid_d;
         kb_dx_q    <= kb_dx_d;
      end
   end

   assign in_hitstun   = (state_q == S_HITSTUN);
   assign in_blockstun = (state_q == S_BLOCKSTUN);
   assign ko           = (state_q == S_KO);
   assign health       = health_q;
   assign hit_event    = hit_ev_q;
   assign block_event  = blk_ev_q;
   assign kb_valid     = kb_valid_q;
   assign kb_dx        = kb_dx_q;

endmodule

// File: tb/tb_hit_reaction_ctrl.sv
// Self-checking bench for hit_reaction_ctrl: per-frame vector table with a
// scoreboard queue, plus hand sequences for non-tick contacts and async reset.
module tb_hit_reaction_ctrl;
   import fight_pkg::*;

   typedef struct {
      logic hit;
      logic blk;
      logic face;
      logic rr;
      logic hs;
      logic bs;
      logic ko;
      int   hp;
      logic hev;
      logic bev;
      int   kb;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic clk          = 1'b0;
   logic rst_n        = 1'b1;
   logic frame_tick   = 1'b0;
   logic round_reset  = 1'b0;
   logic got_hit      = 1'b0;
   logic got_blocked  = 1'b0;
   logic facing_right = 1'b0;

   logic                      in_hitstun;
   logic                      in_blockstun;
   logic                      ko;
   logic [7:0]                health;
   logic                      hit_event;
   logic                      block_event;
   logic                      kb_valid;
   logic signed [COORD_W-1:0] kb_dx;

   hit_reaction_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick   (frame_tick),
      .round_reset  (round_reset),
      .got_hit      (got_hit),
      .got_blocked  (got_blocked),
      .facing_right (facing_right),
      .in_hitstun   (in_hitstun),
      .in_blockstun (in_blockstun),
      .ko           (ko),
      .health       (health),
      .hit_event    (hit_event),
      .block_event  (block_event),
      .kb_valid     (kb_valid),
      .kb_dx        (kb_dx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic h, input logic b, input logic f, input logic r,
                               input logic hs, input logic bs, input logic k, input int hp,
                               input logic hev, input logic bev, input int kb);
      vec_t v;
      v.hit = h;  v.blk = b;  v.face = f;  v.rr = r;
      v.hs  = hs; v.bs  = bs; v.ko   = k;  v.hp = hp;
      v.hev = hev; v.bev = bev; v.kb = kb;
      vecs.push_back(v);
   endfunction

   function automatic void add_quiet(input int n, input logic f, input logic hs,
                                     input logic bs, input logic k, input int hp);
      repeat (n) add(1'b0, 1'b0, f, 1'b0, hs, bs, k, hp, 1'b0, 1'b0, 0);
   endfunction

   // Steady-state outputs (no pulses) expected while nothing is happening.
   task automatic check_quiet(input string tag, input logic hs, input logic bs,
                              input logic k, input int hp);
      check({tag, " in_hitstun"},   in_hitstun,   hs);
      check({tag, " in_blockstun"}, in_blockstun, bs);
      check({tag, " ko"},           ko,           k);
      check({tag, " health"},       health,       hp);
      check({tag, " hit_event"},    hit_event,    0);
      check({tag, " block_event"},  block_event,  0);
      check({tag, " kb_valid"},     kb_valid,     0);
      check({tag, " kb_dx"},        kb_dx,        0);
   endtask

   // One frame: a tick cycle with the contacts, then one non-tick cycle.
   task automatic apply(input vec_t v, input int idx);
      vec_t  e;
      string tag;
      @(negedge clk);
      frame_tick   = 1'b1;
      got_hit      = v.hit;
      got_blocked  = v.blk;
      facing_right = v.face;
      round_reset  = v.rr;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      tag = $sformatf("v%0d", idx);
      check({tag, " in_hitstun"},   in_hitstun,   e.hs);
      check({tag, " in_blockstun"}, in_blockstun, e.bs);
      check({tag, " ko"},           ko,           e.ko);
      check({tag, " health"},       health,       e.hp);
      check({tag, " hit_event"},    hit_event,    e.hev);
      check({tag, " block_event"},  block_event,  e.bev);
      check({tag, " kb_valid"},     kb_valid,     e.hev | e.bev);
      check({tag, " kb_dx"},        kb_dx,        e.kb);
      @(negedge clk);
      frame_tick  = 1'b0;
      round_reset = 1'b0;
      @(posedge clk);
      #1;
      check_quiet({tag, " gap"}, e.hs, e.bs, e.ko, e.hp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Hit held for 5 ticks facing right: one event, 20 frames of hitstun.
      add(1, 0, 1, 0, 1, 0, 0, 80, 1, 0, -8);
      repeat (4) add(1, 0, 1, 0, 1, 0, 0, 80, 0, 0, 0);
      add_quiet(15, 1, 1, 0, 0, 80);
      add_quiet(1, 1, 0, 0, 0, 80);
      add(0, 0, 1, 1, 0, 0, 0, 100, 0, 0, 0);
      // Single-tick block facing left.
      add(0, 1, 0, 0, 0, 1, 0, 100, 0, 1, 3);
      add_quiet(9, 0, 0, 1, 0, 100);
      add_quiet(1, 0, 0, 0, 0, 100);
      // Guard crush: block, release, hit two ticks after the block.
      add(0, 1, 1, 0, 0, 1, 0, 100, 0, 1, -3);
      add_quiet(1, 1, 0, 1, 0, 100);
      add(1, 0, 1, 0, 1, 0, 0, 80, 1, 0, -8);
      add_quiet(19, 1, 1, 0, 0, 80);
      add_quiet(1, 1, 0, 0, 0, 80);
      add(0, 0, 1, 1, 0, 0, 0, 100, 0, 0, 0);
      // Hit and block together: hit path only.
      add(1, 1, 0, 0, 1, 0, 0, 80, 1, 0, 8);
      add_quiet(19, 0, 1, 0, 0, 80);
      add_quiet(1, 0, 0, 0, 0, 80);
      add(0, 0, 1, 1, 0, 0, 0, 100, 0, 0, 0);
      // Five separated hits down to KO; a re-hit during hitstun is ignored.
      for (int k = 1; k <= 4; k++) begin
         add(1, 0, 1, 0, 1, 0, 0, 100 - 20 * k, 1, 0, -8);
         for (int i = 1; i <= 19; i++) begin
            add((k == 1 && i == 2) ? 1'b1 : 1'b0, 0, 1, 0, 1, 0, 0, 100 - 20 * k, 0, 0, 0);
         end
         add_quiet(1, 1, 0, 0, 0, 100 - 20 * k);
      end
      add(1, 0, 1, 0, 0, 0, 1, 0, 1, 0, -8);
      add_quiet(1, 1, 0, 0, 1, 0);
      add(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      add_quiet(1, 1, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      // Round reset together with a contact: reset wins, edge history cleared.
      add(1, 0, 1, 1, 0, 0, 0, 100, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 80, 1, 0, -8);
      add(0, 0, 1, 1, 0, 0, 0, 100, 0, 0, 0);

      // Power-on reset.
      #2 rst_n = 1'b0;
      #1 check_quiet("por", 0, 0, 0, 100);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check_quiet("after_por", 0, 0, 0, 100);

      // Contacts without a frame tick have no effect.
      @(negedge clk);
      got_hit     = 1'b1;
      got_blocked = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 check_quiet($sformatf("no_tick%0d", i), 0, 0, 0, 100);
      end
      @(negedge clk);
      got_hit     = 1'b0;
      got_blocked = 1'b0;

      foreach (vecs[i]) apply(vecs[i], i);

      // Async reset in hitstun with stun_cnt = 7.
      begin
         vec_t h;
         h = vecs[0];
         apply(h, 1000);
         for (int i = 0; i < 13; i++) begin
            vec_t q;
            q = vecs[0];
            q.hit = 1'b0; q.hev = 1'b0; q.kb = 0;
            apply(q, 1001 + i);
         end
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_quiet("async_rst", 0, 0, 0, 100);
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      #1 check_quiet("rst_held", 0, 0, 0, 100);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vec_t z;
         z = vecs[0];
         z.hit = 1'b0; z.hs = 1'b0; z.hp = 100; z.hev = 1'b0; z.kb = 0;
         apply(z, 2000 + i);
      end

      check("scoreboard empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
